stream_demux1to4: RTL and testbench

- 1-to-4 streaming demultiplexer. It is the inverse of the team's 4:1 select path.
- One valid/ready input stream is steered, beat by beat, to one of four output channels chosen by `in_sel`.
- Each output channel has a one-entry registered slot, so downstream stalls on one channel do not block traffic to the others.
- Sits between a single producer (e.g. UART RX / test pattern source) and four independent consumers.

---
 rtl/stream_demux1to4_pkg.sv | 20 ++
 rtl/stream_demux1to4_slot.sv | 34 +++
 rtl/stream_demux1to4.sv | 75 +++++++
 tb/tb_stream_demux1to4.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux1to4_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel count,
// select width, lock-state encoding and the select one-hot decoder.
package stream_demux1to4_pkg;

  localparam int DEMUX_NUM_OUT = 4;
  localparam int SEL_W         = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  function automatic logic [DEMUX_NUM_OUT-1:0] sel_onehot(input sel_t s);
    sel_onehot    = '0;
    sel_onehot[s] = 1'b1;
  endfunction

endpackage

// File: rtl/stream_demux1to4_slot.sv
// One-entry registered output slot (module demux_slot); a load and a drain
// in the same cycle keep valid high, giving one beat per cycle.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  // Stage p1: registered slot contents
  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= din;
    end else if (vld_p1 && ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign valid = vld_p1;
  assign dout  = data_p1;

endmodule

// File: rtl/stream_demux1to4.sv
// 1-to-4 valid/ready demultiplexer with a one-entry slot per channel.
// Optional packet lock (pins the channel until in_last) under DEMUX_PKT_LOCK_EN.
module stream_demux1to4
  import stream_demux1to4_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = DEMUX_NUM_OUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_last,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data
);

  sel_t                esel;
  logic                accept;
  logic [NUM_OUT-1:0]  load_vec;

`ifdef DEMUX_PKT_LOCK_EN
  lock_state_t state;
  sel_t        lock_sel;

  // Once a multi-beat packet starts, stay on its channel until in_last
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      lock_sel <= '0;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          if (!in_last) begin
            state    <= ST_LOCKED;
            lock_sel <= in_sel;
          end
        end
        ST_LOCKED: begin
          if (in_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign esel = (state == ST_LOCKED) ? lock_sel : in_sel;
`else
  logic unused_last;
  assign unused_last = in_last;
  assign esel        = in_sel;
`endif

  assign in_ready = ~out_valid[esel] | out_ready[esel];
  assign accept   = in_valid & in_ready;
  assign load_vec = accept ? sel_onehot(esel) : '0;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load_vec[k]),
      .din  (in_data),
      .ready(out_ready[k]),
      .valid(out_valid[k]),
      .dout (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_stream_demux1to4.sv
// Scoreboard bench for stream_demux1to4: the driver queues expected beats
// per channel, the monitor pops them as each channel hands a beat off.
module tb_stream_demux1to4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_last;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];

  logic       m_locked = 1'b0;
  logic [1:0] m_sel    = 2'd0;

  stream_demux1to4 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] chan_data(input int k);
    return out_data[k*8 +: 8];
  endfunction

  task automatic push_exp(input logic [1:0] ch, input logic [7:0] d);
    case (ch)
      2'd0: q0.push_back(d);
      2'd1: q1.push_back(d);
      2'd2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  // Reference routing: destination channel for an accepted beat
  task automatic accept_model(input logic [1:0] sel, input logic last, input logic [7:0] d);
    logic [1:0] ch;
`ifdef DEMUX_PKT_LOCK_EN
    ch = m_locked ? m_sel : sel;
    if (!m_locked && !last) begin
      m_locked = 1'b1;
      m_sel    = sel;
    end else if (m_locked && last) begin
      m_locked = 1'b0;
    end
`else
    ch = sel;
`endif
    push_exp(ch, d);
  endtask

  // Present one beat until accepted (bounded), returning at posedge+1
  task automatic send(input logic [1:0] sel, input logic [7:0] d, input logic last);
    bit got = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    in_last  = last;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (in_ready) begin
        accept_model(sel, last, d);
        got = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) check("send_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    for (int k = 0; k < 4; k++) begin
      if (out_valid[k] && out_ready[k]) begin
        int sz;
        case (k)
          0: sz = q0.size();
          1: sz = q1.size();
          2: sz = q2.size();
          default: sz = q3.size();
        endcase
        if (sz == 0) begin
          check("mon_unexpected_beat", {24'd0, chan_data(k)}, 32'hFFFF_FFFF);
        end else begin
          case (k)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
          endcase
          check($sformatf("mon_ch%0d_data", k), {24'd0, chan_data(k)}, {24'd0, e});
        end
      end
    end
  end

  task automatic clear_model();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    m_locked = 1'b0;
  endtask

  initial begin
    logic [1:0] pk_sel  [4] = '{2'd1, 2'd3, 2'd0, 2'd2};
    logic       pk_last [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef DEMUX_PKT_LOCK_EN
    logic [3:0] pk_exp  [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
`else
    logic [3:0] pk_exp  [4] = '{4'b0010, 4'b1000, 4'b0001, 4'b0100};
`endif

    // Reset with a beat presented: nothing accepted, slots empty
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hFF; in_last = 1'b1;
    out_ready = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_out_valid", {28'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_no_beat", {28'd0, out_valid}, 32'd0);

    // Routing to each channel with one-cycle latency
    out_ready = 4'b1111;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'hA0 + 8'(i);
      send(2'(i), d, 1'b1);
      @(negedge clk);
      check("route_valid", {28'd0, out_valid}, 32'd1 << i);
      check("route_data", {24'd0, chan_data(i)}, {24'd0, d});
      @(posedge clk); #1;
    end

    // Backpressure on ch2 must not block ch1
    out_ready = 4'b1011;
    send(2'd2, 8'h55, 1'b1);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h66; in_last = 1'b1;
    @(negedge clk);
    check("bp_block_ready", {31'd0, in_ready}, 32'd0);
    check("bp_ch2_held", {24'd0, chan_data(2)}, 32'h55);
    @(posedge clk); #1;
    in_sel = 2'd1; in_data = 8'h77;
    @(negedge clk);
    check("bp_switch_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) accept_model(2'd1, 1'b1, 8'h77);
    @(posedge clk); #1;
    in_sel = 2'd2; in_data = 8'h66; out_ready = 4'b1111;
    @(negedge clk);
    check("bp_ch1_valid", {31'd0, out_valid[1]}, 32'd1);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) accept_model(2'd2, 1'b1, 8'h66);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_ch2_new", {24'd0, chan_data(2)}, 32'h66);
    @(posedge clk); #1;

    // Sustained one beat per cycle on ch3
    in_valid = 1'b1; in_sel = 2'd3; in_last = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = (i < 16);
      in_data  = 8'(i);
      @(negedge clk);
      if (i > 0) begin
        check("tput_valid", {31'd0, out_valid[3]}, 32'd1);
        check("tput_data", {24'd0, chan_data(3)}, i - 1);
      end
      if (i < 16) begin
        check("tput_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready) accept_model(2'd3, 1'b1, 8'(i));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // Packet steering (locked or per-beat depending on build)
    for (int i = 0; i < 4; i++) begin
      send(pk_sel[i], 8'hC0 + 8'(i), pk_last[i]);
      @(negedge clk);
      check("pkt_route", {28'd0, out_valid}, {28'd0, pk_exp[i]});
      @(posedge clk); #1;
    end

    // Reset in the middle of a packet releases the lock
    send(2'd1, 8'hD1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    check("midrst_cleared", {28'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    send(2'd3, 8'hD3, 1'b1);
    @(negedge clk);
    check("midrst_route", {28'd0, out_valid}, 32'b1000);
    check("midrst_data", {24'd0, chan_data(3)}, 32'hD3);

    // Drain and confirm every expected beat was observed
    repeat (3) @(posedge clk);
    #1;
    check("drain_q0", q0.size(), 32'd0);
    check("drain_q1", q1.size(), 32'd0);
    check("drain_q2", q2.size(), 32'd0);
    check("drain_q3", q3.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
